booth_multiplier_seq: RTL and testbench
=======================================

Name: booth_multiplier_seq

Overview:
- Sequential radix-4 Booth multiplier for the MIPS datapath. Services MULT/MULTU and writes the HI/LO pair.
- Instantiates the existing 3-bit Booth recoding stage, which sits directly upstream of it.
- Each RUN cycle, the recoder's op1/op0 commands drive this block's add/subtract of the shifted multiplicand into a product accumulator.
- Start/busy/done handshake with the execute stage.

Parameters:
- WIDTH, 32, operand width in bits; must be even.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; captured with start
- multiplicand  input  WIDTH  operand A (rs); captured with start
- multiplier  input  WIDTH  operand B (rt); captured with start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; hi/lo valid
- hi  output  WIDTH  upper half of the 2*WIDTH product
- lo  output  WIDTH  lower half of the product

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; internal registers cleared.
- rst takes priority over every other input, including mid-RUN. An in-flight operation is discarded and no done pulse is produced.
- Iteration count: N = WIDTH/2 + 1 (17 for WIDTH=32), fixed for both signed and unsigned operations.
- Capture on start:
  - A is extended to 2*WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - B is extended to WIDTH+2 bits the same way, then a 0 is appended below the LSB, giving a WIDTH+3-bit register.
  - Accumulator is cleared.
  - Iteration counter i is set to 0.
- Per RUN cycle:
  - The low 3 bits of the B register feed the recoder.
  - Recoder commands are: 00 = nop, 01 = add, 10 = sub. Code 11 is never generated; if it occurs, treat it as nop.
  - op0 applies ±(A << 2i) and op1 applies ±(A << (2i+1)); both terms are summed into the accumulator in the same cycle.
  - All arithmetic is modulo 2^(2*WIDTH+2).
  - The B register then shifts right by 2 (arithmetic shift) and i increments.
- Result: {hi, lo} = accumulator[2*WIDTH-1:0]. For either signedness the value is exact modulo 2^(2*WIDTH).
- State machine:
  - IDLE:
    - start=1 -> capture operands, enter RUN, busy=1.
    - start=0 -> stay in IDLE.
  - RUN:
    - i < N-1 -> stay in RUN.
    - i = N-1 -> enter DONE.
    - start is ignored throughout RUN; captured operands are not disturbed.
  - DONE:
    - Lasts exactly one cycle; busy=0, done=1, hi/lo updated at entry to DONE.
    - start=1 -> capture the new operation and go to RUN (back-to-back; no IDLE bubble).
    - start=0 -> go to IDLE.
- Latency: start sampled at edge E0.
  - busy is high from E0 through edge E0+N.
  - done is high for the cycle following edge E0+N.
- hi/lo hold the last result until the next DONE or a reset. A new start alone does not change them.
- busy and done are never high in the same cycle.

Test Plan:
- Basic signed: rst for 2 cycles, then start, is_signed=1, A=3, B=5 -> done exactly 18 cycles after the start edge (17 busy + 1); hi=0x00000000, lo=0x0000000F.
- Negative signed: is_signed=1, A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
- Unsigned max: is_signed=0, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed corner: is_signed=1, A=B=0x80000000 -> hi=0x40000000, lo=0. Then A=0x80000000, B=0x7FFFFFFF -> hi=0xC0000000, lo=0x80000000.
- Handshake:
  - Pulse start again with different operands mid-RUN -> ignored; result matches the first operands.
  - Assert start during the DONE cycle -> busy rises on the next cycle; the second result arrives 18 cycles later.
- Reset mid-operation: assert rst at iteration 8 -> the next cycle shows busy=0, done=0, hi=lo=0, state IDLE. No done pulse follows. A fresh start afterwards completes correctly (7*(-6) -> hi=0xFFFFFFFF, lo=0xFFFFFFD6).

Source files
------------

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-4 Booth multiplier for MULT/MULTU: one recoded digit pair per
// RUN cycle, start/busy/done handshake, and a HI/LO result that is held between operations.

module booth_recoder_3b (
    input  logic [2:0] i_bits,
    output logic [1:0] o_op1,
    output logic [1:0] o_op0
);
    // Commands: 00 = nop, 01 = add, 10 = sub. op1 weighs 2*A and op0 weighs A.
    always_comb begin
        o_op1 = 2'b00;
        o_op0 = 2'b00;
        case (i_bits)
            3'b001, 3'b010: o_op0 = 2'b01;
            3'b011:         o_op1 = 2'b01;
            3'b100:         o_op1 = 2'b10;
            3'b101, 3'b110: o_op0 = 2'b10;
            default: begin
                o_op1 = 2'b00;
                o_op0 = 2'b00;
            end
        endcase
    end
endmodule

module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_a;
    logic [BW-1:0]   r_b;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [AW-1:0]   w_a_ext;
    logic [BW-1:0]   w_b_ext;
    logic [1:0]      w_op1;
    logic [1:0]      w_op0;
    logic [AW-1:0]   w_term0;
    logic [AW-1:0]   w_term1;
    logic [AW-1:0]   w_acc_next;
    logic            w_last;
    logic            w_capture;

    assign w_a_ext = is_signed ? {{(WIDTH + 2){multiplicand[WIDTH-1]}}, multiplicand}
                               : {{(WIDTH + 2){1'b0}}, multiplicand};
    assign w_b_ext = {(is_signed ? {2{multiplier[WIDTH-1]}} : 2'b00), multiplier, 1'b0};

    booth_recoder_3b u_recoder (
        .i_bits (r_b[2:0]),
        .o_op1  (w_op1),
        .o_op0  (w_op0)
    );

    // r_a is pre-shifted by 2 every iteration, so it already equals A << 2i.
    always_comb begin
        w_term0 = '0;
        w_term1 = '0;
        case (w_op0)
            2'b01:   w_term0 = r_a;
            2'b10:   w_term0 = -r_a;
            default: w_term0 = '0;
        endcase
        case (w_op1)
            2'b01:   w_term1 = {r_a[AW-2:0], 1'b0};
            2'b10:   w_term1 = -{r_a[AW-2:0], 1'b0};
            default: w_term1 = '0;
        endcase
    end

    assign w_acc_next = r_acc + w_term0 + w_term1;
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_capture  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_a   <= w_a_ext;
                r_b   <= w_b_ext;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_a   <= {r_a[AW-3:0], 2'b00};
                r_b   <= {{2{r_b[BW-1]}}, r_b[BW-1:2]};
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                    r_lo <= w_acc_next[WIDTH-1:0];
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and randomized checks of booth_multiplier_seq against a plain
// arithmetic product model, including handshake timing and mid-operation reset.

module tb_booth_multiplier_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int lat;
  int busy_n;
  bit overlap;

  booth_multiplier_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // product model: extend both operands to 64 bits and multiply modulo 2^64
  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver: present operands with start for one edge; returns just after that edge
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    is_signed    = s;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  // bounded wait for done; lat is the sample index (1 = first sample after the start edge)
  task automatic wait_done(input int first_idx);
    lat     = first_idx;
    busy_n  = 0;
    overlap = 1'b0;
    while (!done && lat < 60) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    if (busy && done) overlap = 1'b1;
    chk("done_seen", {63'h0, done}, 64'h1);
  endtask

  logic [31:0] d_a [6];
  logic [31:0] d_b [6];
  bit          d_s [6];
  logic [63:0] d_p [6];
  logic [31:0] corners [5];

  initial begin
    logic [63:0] prev;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    int          gap;
    int          done_cnt;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; multiplicand = '0; multiplier = '0;
    step();
    step();
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_state", {62'h0, dbg_state}, 64'h0);
    rst = 1'b0;
    step();

    // basic signed 3*5 with exact timing
    start_op(1'b1, 32'd3, 32'd5);
    wait_done(1);
    chk("basic_latency", 64'(lat), 64'd18);
    chk("basic_busy_cycles", 64'(busy_n), 64'd17);
    chk("basic_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
    step();
    chk("done_one_cycle", {62'h0, busy, done}, 64'h0);
    chk("hold_after_done", {hi, lo}, 64'h0000_0000_0000_000F);

    // directed corners with explicit expected products
    d_s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    d_a = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0007};
    d_b = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFA};
    d_p = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
            64'hC000_0000_8000_0000, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFD6};
    for (int k = 0; k < 6; k++) begin
      start_op(d_s[k], d_a[k], d_b[k]);
      wait_done(1);
      chk($sformatf("dir%0d_latency", k), 64'(lat), 64'd18);
      chk($sformatf("dir%0d_hilo", k), {hi, lo}, d_p[k]);
      step();
    end

    // start pulsed mid-RUN is ignored
    start_op(1'b1, 32'd123, 32'hFFFF_FE38);
    repeat (4) step();
    start_op(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    multiplicand = 32'h0; multiplier = 32'h0;
    wait_done(6);
    chk("midrun_latency", 64'(lat), 64'd18);
    chk("midrun_hilo", {hi, lo}, ref_mul(1'b1, 32'd123, 32'hFFFF_FE38));
    prev = {hi, lo};

    // back-to-back start in the DONE cycle; result holds until the next DONE
    start_op(1'b0, 32'h0001_0000, 32'h0003_0000);
    chk("b2b_busy", {62'h0, busy, done}, 64'h2);
    chk("b2b_hold", {hi, lo}, prev);
    wait_done(1);
    chk("b2b_latency", 64'(lat), 64'd18);
    chk("b2b_hilo", {hi, lo}, 64'h0000_0003_0000_0000);

    // randomized operands, with occasional corner values and idle gaps
    corners = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    for (int k = 0; k < 24; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      start_op(rs, ra, rb);
      wait_done(1);
      chk($sformatf("rnd%0d_latency s=%0d a=%h b=%h", k, rs, ra, rb), 64'(lat), 64'd18);
      chk($sformatf("rnd%0d_hilo s=%0d a=%h b=%h", k, rs, ra, rb), {hi, lo}, ref_mul(rs, ra, rb));
      chk($sformatf("rnd%0d_overlap", k), {63'h0, overlap}, 64'h0);
    end
    step();

    // reset at iteration 8 discards the operation
    start_op(1'b1, 32'd1000, 32'd2000);
    repeat (8) step();
    chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy_done", {62'h0, busy, done}, 64'h0);
    chk("midrst_hilo", {hi, lo}, 64'h0);
    chk("midrst_state", {62'h0, dbg_state}, 64'h0);
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done || busy) done_cnt++;
    end
    chk("midrst_no_done", 64'(done_cnt), 64'h0);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFA);
    wait_done(1);
    chk("post_rst_latency", 64'(lat), 64'd18);
    chk("post_rst_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
